// File: rtl/wb_intc.sv
// Wishbone interrupt controller: N synchronised request lines, edge/level latch, mask, fixed priority, in-service tracking.
// Latency: irq_i to intr_o is SYNC_STAGES+2 clk edges; bus ack one cycle after cyc&stb; vec_o updates on the INTA edge.
// Backpressure: single-cycle ack pulse, so back-to-back requests are acked every other cycle; no stalls otherwise.
// Optional: define INTC_AUTO_EOI_EN so that INTA never sets INSERV (nesting by mask only).
module wb_intc #(
    parameter int          N_IRQ       = 4,
    parameter int          SYNC_STAGES = 2,
    parameter logic [7:0]  VEC_BASE    = 8'h0C,
    parameter logic [7:0]  SPUR_VEC    = 8'h0F
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [N_IRQ-1:0]  irq_i,
    input  logic              inta_i,
    output logic              intr_o,
    output logic [7:0]        vec_o,
    input  logic [2:0]        wb_adr_i,
    input  logic [15:0]       wb_dat_i,
    output logic [15:0]       wb_dat_o,
    input  logic [1:0]        wb_sel_i,
    input  logic              wb_we_i,
    input  logic              wb_stb_i,
    input  logic              wb_cyc_i,
    output logic              wb_ack_o
);

    // Lowest set bit index, 5'h1F when the vector is empty.
    function automatic logic [4:0] lowest(input logic [N_IRQ-1:0] v);
        lowest = 5'h1F;
        for (int i = N_IRQ - 1; i >= 0; i--) begin
            if (v[i]) lowest = 5'(i);
        end
    endfunction

    function automatic logic [15:0] zext(input logic [N_IRQ-1:0] v);
        zext = '0;
        zext[N_IRQ-1:0] = v;
    endfunction

    logic [SYNC_STAGES-1:0][N_IRQ-1:0] sync_q;
    logic [N_IRQ-1:0] s, s_prev_q, rise;
    logic [N_IRQ-1:0] mask_q, mode_q, pend_q, inserv_q;
    logic [N_IRQ-1:0] mask_d, mode_d, pend_d, inserv_d;
    logic [N_IRQ-1:0] eligible, win_oh, wclr, eoi_clr, wdat;
    logic [4:0]       el_idx, is_idx;
    logic             win_vld, inta_ack, req, wr;
    logic             ack_q, intr_q, intr_d, inta_q;
    logic [7:0]       vec_q, vec_d;
    logic [15:0]      dat_q, rdat;
    logic             unused_dat;

    assign unused_dat = ^wb_dat_i;

    assign s        = sync_q[SYNC_STAGES-1];
    assign rise     = s & ~s_prev_q;
    assign req      = wb_cyc_i & wb_stb_i & ~ack_q;
    assign wr       = req & wb_we_i & (|wb_sel_i);
    assign wdat     = wb_dat_i[N_IRQ-1:0];
    assign eligible = pend_q & ~mask_q;
    assign el_idx   = lowest(eligible);
    assign is_idx   = lowest(inserv_q);
    // An empty INSERV yields 5'h1F, so any eligible channel beats it.
    assign win_vld  = (el_idx != 5'h1F) && (el_idx < is_idx);
    assign inta_ack = inta_i & ~inta_q;

    // Per-channel clear/select vectors: winner one-hot, PEND write-clear, EOI clear.
    always_comb begin
        win_oh  = '0;
        wclr    = '0;
        eoi_clr = '0;
        for (int k = 0; k < N_IRQ; k++) begin
            win_oh[k] = win_vld && (el_idx == 5'(k));
            if (wr && wb_adr_i == 3'd3) wclr[k] = wdat[k];
            if (wr && wb_adr_i == 3'd0) begin
                if (wb_dat_i[15]) eoi_clr[k] = (wb_dat_i[3:0] == 4'(k));
                else              eoi_clr[k] = (is_idx == 5'(k));
            end
        end
    end

    // Next-state for control registers; a new edge always beats a same-cycle clear.
    always_comb begin
        mask_d   = mask_q;
        mode_d   = mode_q;
        if (wr && wb_adr_i == 3'd1) mask_d = wdat;
        if (wr && wb_adr_i == 3'd2) mode_d = wdat;
        pend_d   = (mode_q & ((pend_q & ~wclr & ~(inta_ack ? win_oh : '0)) | rise))
                 | (~mode_q & s);
        inserv_d = inserv_q & ~eoi_clr;
`ifndef INTC_AUTO_EOI_EN
        if (inta_ack) inserv_d = inserv_d | win_oh;
`endif
        vec_d    = vec_q;
        if (inta_ack) vec_d = win_vld ? (VEC_BASE + {3'b000, el_idx}) : SPUR_VEC;
        intr_d   = inta_ack ? 1'b0 : win_vld;
    end

    // Register read mux, sampled on the ack edge.
    always_comb begin
        rdat = '0;
        case (wb_adr_i)
            3'd1:    rdat = zext(mask_q);
            3'd2:    rdat = zext(mode_q);
            3'd3:    rdat = zext(pend_q);
            3'd4:    rdat = zext(inserv_q);
            3'd5:    rdat = {intr_q, 10'b0, el_idx};
            default: rdat = '0;
        endcase
    end

    // Request synchroniser plus previous-sample register for edge detection.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync_q   <= '0;
            s_prev_q <= '0;
        end else begin
            sync_q   <= {sync_q[SYNC_STAGES-2:0], irq_i};
            s_prev_q <= s;
        end
    end

    // Controller state: pending, in-service, mask, mode, intr, vector, INTA edge.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            mask_q   <= '1;
            mode_q   <= '1;
            pend_q   <= '0;
            inserv_q <= '0;
            intr_q   <= 1'b0;
            vec_q    <= SPUR_VEC;
            inta_q   <= 1'b0;
        end else begin
            mask_q   <= mask_d;
            mode_q   <= mode_d;
            pend_q   <= pend_d;
            inserv_q <= inserv_d;
            intr_q   <= intr_d;
            vec_q    <= vec_d;
            inta_q   <= inta_i;
        end
    end

    // Bus handshake: single-cycle ack with registered read data.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ack_q <= 1'b0;
            dat_q <= '0;
        end else begin
            ack_q <= req;
            if (req) dat_q <= rdat;
        end
    end

    assign wb_ack_o = ack_q;
    assign wb_dat_o = dat_q;
    assign intr_o   = intr_q;
    assign vec_o    = vec_q;

endmodule

// File: doc/wb_intc.md
Name: wb_intc

Overview:
- Parametrised Wishbone interrupt controller for the Zet 80186 co-processor SoC.
- Replaces the fixed single-source edge latch and constant INTA vector in the top level.
- Synchronises N asynchronous active-high request lines and latches edges or levels per channel, with masking and fixed priority.
- Drives intr to the CPU, supplies the vector during INTA, and tracks in-service state cleared by EOI writes.
- Sits on the interrupt-control I/O slot (0xFF20-0xFF3E) of wb_switch.

Parameters:
N_IRQ, 4, number of request channels (1..16); channel 0 is highest priority.
SYNC_STAGES, 2, flip-flop stages on each irq_i line (>=2).
VEC_BASE, 8'h0C, vector returned for channel k is VEC_BASE+k, truncated to 8 bits.
SPUR_VEC, 8'h0F, vector returned when INTA finds nothing eligible.

Ports:
clk  in  1  system clock
rst  in  1  asynchronous active-high reset
irq_i  in  N_IRQ  asynchronous request lines, active-high
inta_i  in  1  CPU interrupt acknowledge (zet wb_tgc_o), level
intr_o  out  1  interrupt request to CPU (zet wb_tgc_i)
vec_o  out  8  vector; top level drives it onto dat_i while inta is high
wb_adr_i  in  3  register select (word address bits 3:1)
wb_dat_i  in  16  write data
wb_dat_o  out  16  read data
wb_sel_i  in  2  byte selects; any write with wb_sel_i!=0 writes the full word
wb_we_i  in  1  write enable
wb_stb_i  in  1  strobe
wb_cyc_i  in  1  cycle
wb_ack_o  out  1  acknowledge

Behaviour:
- Reset: async, active-high. All outputs 0 except vec_o=SPUR_VEC. PEND=0, INSERV=0, MASK=all ones, MODE=all ones (edge). Sync chains cleared.
- Reset mid-operation aborts any bus cycle; ack stays 0 until rst deasserts.
- Register map (16-bit words; bits at and above N_IRQ read 0 and ignore writes):
  - 0 EOI, write-only, reads 0. bit15=0: non-specific, clears the lowest-index INSERV bit. bit15=1: specific, clears INSERV[wb_dat_i[3:0]]. An index >=N_IRQ is a no-op.
  - 1 MASK, read/write; 1 = masked.
  - 2 MODE, read/write; 1 = edge, 0 = level.
  - 3 PEND, read; write-1-to-clear, edge channels only.
  - 4 INSERV, read-only.
  - 5 STATUS, read: bit15 = intr_o; bits 4:0 = index of the highest-priority eligible channel, 5'h1F if none.
  - 6, 7: read 0, writes ignored.
- Bus handshake:
  - wb_ack_o rises one cycle after cyc&stb is seen with ack low. It is a single-cycle pulse, so back-to-back requests are acked every other cycle.
  - Register writes commit on the ack edge.
  - wb_dat_o is registered and valid with ack.
- Request path:
  - Each irq_i passes through SYNC_STAGES flip-flops, giving s.
  - Edge channel: PEND[k] sets on s rising (s & ~s_prev).
  - Level channel: PEND[k] = s each cycle and ignores write-clear.
- Arbitration:
  - Eligible = PEND & ~MASK.
  - The winner is the lowest eligible index, and it must be strictly lower than the lowest INSERV index (any index if INSERV=0).
  - intr_o is registered: intr_o <= (winner exists).
  - With SYNC_STAGES=2, intr_o rises on the 4th clk edge after irq_i rises.
- INTA (acted on at the first cycle inta_i is seen high, i.e. a rising edge of registered inta):
  - If a winner exists: vec_o <= VEC_BASE+winner, INSERV[winner] set, PEND[winner] cleared (edge mode only), intr_o cleared on the next edge.
  - If no winner: vec_o <= SPUR_VEC and no state change.
  - vec_o holds until the next INTA.
  - Sustained inta_i high does not re-acknowledge.
- Simultaneous events:
  - New edge vs INTA clear or write-clear on the same channel in the same cycle: the set wins.
  - EOI write and INTA in the same cycle: the EOI clear is applied first, then INTA arbitration uses the INSERV value before the write.
  - Masking a channel after intr_o is asserted but before INTA: the INTA returns SPUR_VEC.
- Wrap: VEC_BASE+k is taken modulo 256.

Optional Feature:
- Macro: INTC_AUTO_EOI_EN.
- Defined: INTA does not set INSERV; the EOI register is still writable. INSERV then reads 0, so every winner is eligible and nesting is by mask only.
- Undefined: the full in-service and EOI behaviour above.

Test Plan:
1. After reset, read MASK=16'h000F and MODE=16'h000F; write MASK=0; pulse irq_i[2] -> intr_o rises 4 edges later; INTA gives vec_o=8'h0E, INSERV=16'h0004, PEND=0, intr_o=0.
2. Channels 3 and 1 pending with INSERV[2] set -> INTA gives 8'h0D. Channel 3 is not granted until EOI; non-specific EOI clears bit1, a second clears bit2, then channel 3 gives 8'h0F.
3. Level mode on channel 0 (MODE=16'h000E), irq_i[0] held high -> after INTA and EOI, intr_o re-asserts. Drop irq_i[0] -> PEND[0]=0 three edges later.
4. Mask channel 1 after intr_o rises -> INTA gives SPUR_VEC 8'h0F and INSERV stays 0.
5. Write-1-to-clear PEND[2] in the same cycle as a new irq_i[2] edge reaches the sync output -> PEND[2] stays 1.
6. Assert rst during a pending bus cycle with PEND=4'hA -> all registers are at reset values, no ack is issued, and intr_o=0.
